// File: rtl/dec_pkg.sv
// Shared types and helpers for the registered scan decoder.
// Holds the FSM state encoding, a one-hot builder and a width helper.
package dec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam int MAX_N = 32;

  // Bits needed to count 0..value-1, never less than one.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic [MAX_N-1:0] onehot(input int unsigned idx, input int unsigned n);
    logic [MAX_N-1:0] r;
    r = '0;
    if (idx < n) r[idx[4:0]] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/scan_decoder_dwell_counter.sv
// Dwell counter for the scan decoder: counts 0..DWELL-1 while run is high.
// tick flags the last cycle of a dwell; clear has priority over run.
module dwell_counter
  import dec_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int CW = clog2_min1(DWELL);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Explicit compare so non-power-of-two dwells wrap correctly.
  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered binary-to-one-hot decoder with an automatic scan mode.
// y, idx and wrap are all registered and change on the same clock edge.
module scan_decoder
  import dec_pkg::*;
#(
  parameter int SEL_W      = 2,
  parameter int DWELL      = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  output logic [(1<<SEL_W)-1:0] y,
  output logic [SEL_W-1:0]      idx,
  output logic                  wrap
);

  localparam int N = 1 << SEL_W;
  localparam logic [N-1:0]     Y_IDLE   = {N{ACTIVE_LOW != 0}};
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [N-1:0]     y_q, y_d;
  logic             wrap_q, wrap_d;
  // Set once scanning has run; lets IDLE distinguish "paused scan" from "fresh".
  logic             resume_q, resume_d;
  logic             run;
  logic             clear;
  logic             tick;

  dwell_counter #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .clear (clear),
    .tick  (tick)
  );

  always_comb begin
    state_d  = IDLE;
    idx_d    = idx_q;
    y_d      = Y_IDLE;
    wrap_d   = 1'b0;
    resume_d = resume_q;
    run      = 1'b0;
    clear    = 1'b0;

    if (!en) begin
      state_d = IDLE;
    end else if (!mode) begin
      state_d  = DIRECT;
      idx_d    = sel;
      clear    = 1'b1;
      resume_d = 1'b0;
    end else begin
      state_d  = SCAN;
      resume_d = 1'b1;
      if (state_q == SCAN || (state_q == IDLE && resume_q)) begin
        run = 1'b1;
        if (tick) begin
          idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          wrap_d = (idx_q == IDX_LAST);
        end
      end else begin
        idx_d = '0;
        clear = 1'b1;
      end
    end

    // Inactive mask XOR one-hot gives one-hot or one-cold as configured.
    if (en) begin
      y_d = N'(onehot(32'(idx_d), N)) ^ Y_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      y_q      <= Y_IDLE;
      wrap_q   <= 1'b0;
      resume_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      y_q      <= y_d;
      wrap_q   <= wrap_d;
      resume_q <= resume_d;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: default instance (2-bit select, dwell 4) and a
// wide active-low instance (3-bit select, dwell 1) share clock and reset.
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_a, mode_a;
  logic [1:0] sel_a;
  logic [3:0] y_a;
  logic [1:0] idx_a;
  logic       wrap_a;
  logic       en_b, mode_b;
  logic [2:0] sel_b;
  logic [7:0] y_b;
  logic [2:0] idx_b;
  logic       wrap_b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       en;
    logic       mode;
    logic [1:0] sel;
    logic [3:0] y;
    logic [1:0] idx;
    logic       wrap;
  } vec_t;

  vec_t       vecs[10];
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  scan_decoder #(.SEL_W(2), .DWELL(4), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .mode(mode_a), .sel(sel_a),
    .y(y_a), .idx(idx_a), .wrap(wrap_a)
  );

  scan_decoder #(.SEL_W(3), .DWELL(1), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .mode(mode_b), .sel(sel_b),
    .y(y_b), .idx(idx_b), .wrap(wrap_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic e, input logic m, input logic [1:0] s);
    en_a   = e;
    mode_a = m;
    sel_a  = s;
  endtask

  task automatic check_a(input string name, input logic [3:0] ey, input logic [1:0] ei,
                         input logic ew);
    chk({name, ".y"}, 32'(y_a), 32'(ey));
    chk({name, ".idx"}, 32'(idx_a), 32'(ei));
    chk({name, ".wrap"}, 32'(wrap_a), 32'(ew));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ei;
    logic [3:0] ey;
    logic [2:0] eib;
    logic [7:0] eyb;

    rst_n = 1'b0;
    drive_a(1'b0, 1'b0, 2'd0);
    en_b   = 1'b0;
    mode_b = 1'b0;
    sel_b  = 3'd0;

    //        en    mode  sel    y        idx    wrap
    vecs[0] = '{1'b1, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 2'd1, 4'b0010, 2'd1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 2'd2, 4'b0100, 2'd2, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 2'd3, 4'b1000, 2'd3, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 2'd2, 4'b0100, 2'd2, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 2'd2, 4'b0000, 2'd2, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 2'd1, 4'b0000, 2'd2, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 2'd3, 4'b0000, 2'd2, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b0};
    vecs[9] = '{1'b1, 1'b0, 2'd3, 4'b1000, 2'd3, 1'b0};

    // Reset values
    repeat (2) step();
    check_a("reset_a", 4'b0000, 2'd0, 1'b0);
    chk("reset_b.y", 32'(y_b), 32'h0000_00ff);
    chk("reset_b.idx", 32'(idx_b), 32'd0);
    chk("reset_b.wrap", 32'(wrap_b), 32'd0);

    // Direct decode and idle hold
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_a(vecs[i].en, vecs[i].mode, vecs[i].sel);
      step();
      check_a($sformatf("vec%0d", i), vecs[i].y, vecs[i].idx, vecs[i].wrap);
    end

    // Scan from reset: 4 cycles per line, wrap when idx returns to 0
    rst_n = 1'b0;
    step();
    @(negedge clk);
    rst_n = 1'b1;
    drive_a(1'b1, 1'b1, 2'd3);
    for (int c = 0; c < 42; c++) begin
      ei = 2'((c / 4) % 4);
      exp_q.push_back(4'(1 << ei));
      step();
      ey = exp_q.pop_front();
      chk($sformatf("scan%0d.y", c), 32'(y_a), 32'(ey));
      chk($sformatf("scan%0d.idx", c), 32'(idx_a), 32'(ei));
      chk($sformatf("scan%0d.wrap", c), 32'(wrap_a), 32'((c > 0) && (c % 16 == 0)));
    end

    // Now at idx 2, dwell 1: pause three cycles then resume dwell 2, 3
    drive_a(1'b0, 1'b1, 2'd3);
    for (int c = 0; c < 3; c++) begin
      step();
      check_a($sformatf("pause%0d", c), 4'b0000, 2'd2, 1'b0);
    end
    drive_a(1'b1, 1'b1, 2'd3);
    step();
    check_a("resume0", 4'b0100, 2'd2, 1'b0);
    step();
    check_a("resume1", 4'b0100, 2'd2, 1'b0);
    step();
    check_a("resume2", 4'b1000, 2'd3, 1'b0);
    step();
    check_a("resume3", 4'b1000, 2'd3, 1'b0);

    // Mid-dwell switch to direct, then back to scan restarts at line 0
    drive_a(1'b1, 1'b0, 2'd1);
    step();
    check_a("to_direct", 4'b0010, 2'd1, 1'b0);
    drive_a(1'b1, 1'b1, 2'd1);
    step();
    check_a("rescan_entry", 4'b0001, 2'd0, 1'b0);
    repeat (12) step();
    check_a("rescan_idx3", 4'b1000, 2'd3, 1'b0);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    check_a("async_rst", 4'b0000, 2'd0, 1'b0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_a("post_rst0", 4'b0001, 2'd0, 1'b0);
    repeat (4) step();
    check_a("post_rst4", 4'b0010, 2'd1, 1'b0);

    // Wide active-low instance, dwell 1
    en_b   = 1'b1;
    mode_b = 1'b1;
    for (int c = 0; c < 17; c++) begin
      step();
      eib = 3'(c % 8);
      eyb = ~8'(1 << eib);
      chk($sformatf("b%0d.y", c), 32'(y_b), 32'(eyb));
      chk($sformatf("b%0d.idx", c), 32'(idx_b), 32'(eib));
      chk($sformatf("b%0d.wrap", c), 32'(wrap_b), 32'((c > 0) && (c % 8 == 0)));
    end
    en_b = 1'b0;
    step();
    chk("b_off.y", 32'(y_b), 32'h0000_00ff);
    chk("b_off.wrap", 32'(wrap_b), 32'd0);
    en_b   = 1'b1;
    mode_b = 1'b0;
    sel_b  = 3'd5;
    step();
    chk("b_direct.y", 32'(y_b), 32'h0000_00df);
    chk("b_direct.idx", 32'(idx_b), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
- Parametrised, registered binary-to-one-hot decoder with enable. It is the sequential successor of the combinational 2-to-4 decoder.
- Two modes:
  - Direct: decodes the `sel` input.
  - Scan: walks the one-hot output through all lines automatically, holding each line for a programmable dwell. Used for display digit select and row strobing.
- Sits between control logic and output drivers.

Parameters:
- SEL_W, 2, select width; output width N = 2**SEL_W (legal 1..5).
- DWELL, 4, clock cycles each line stays active in scan mode (legal >= 1).
- ACTIVE_LOW, 0, 1 inverts `y` at the output register (active line = 0).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  enable; 0 forces all lines inactive and freezes scan state.
- mode  input  1  0 = direct decode, 1 = scan.
- sel  input  SEL_W  line index in direct mode; ignored in scan mode.
- y  output  N  registered one-hot (or one-cold if ACTIVE_LOW) line outputs.
- idx  output  SEL_W  registered index of the currently active line.
- wrap  output  1  one-cycle pulse when scan index advances from N-1 to 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - y = all inactive (0s, or all 1s if ACTIVE_LOW).
  - idx = 0, wrap = 0, dwell counter = 0, state = IDLE.
  - Release is sampled on the next rising clk.
- States: IDLE, DIRECT, SCAN. The state register is updated every clk.
- Transitions:
  - en=0 -> IDLE.
  - en=1, mode=0 -> DIRECT.
  - en=1, mode=1 -> SCAN.
- IDLE:
  - y inactive, wrap=0.
  - idx and dwell counter hold their values. Re-enabling scan resumes where it stopped.
- DIRECT:
  - y <= onehot(sel), idx <= sel. Latency 1 cycle from sel to y.
  - wrap=0. Dwell counter held at 0.
- SCAN:
  - Dwell counter counts 0..DWELL-1. At DWELL-1 it returns to 0 and idx advances by 1 modulo N.
  - y always equals onehot(idx) of the same cycle (y and idx change on the same edge).
- Entry into SCAN:
  - From DIRECT or from reset, entry starts at idx = 0, dwell = 0, y = onehot(0) on the first SCAN cycle.
  - From IDLE (en toggled while mode=1), entry resumes the held idx and dwell.
- wrap:
  - Asserted for exactly the one cycle in which idx becomes 0 through advance from N-1.
  - Not asserted on scan entry or in DIRECT.
- DWELL=1: idx advances every cycle; wrap pulses every N cycles.
- SEL_W=1: N=2, scan toggles between lines.
- Mode change mid-dwell, SCAN->DIRECT: the next edge shows onehot(sel). Scan position is discarded.
- Simultaneous en fall and mode change: en has priority (IDLE).
- Output invariant: exactly one line active when en=1 in the previous cycle. No line active otherwise. No glitch states, because y is registered.
- Dwell counter width: clog2(DWELL), minimum 1 bit. Wrap-around uses explicit compare, not overflow.

Decomposition:
- Shared package `dec_pkg`:
  - state enum {IDLE, DIRECT, SCAN}.
  - Function `onehot(idx, N)`.
  - Clog2 helper constant function.
- Natural sub-module: `dwell_counter` (parametrised DWELL). Inputs clk, rst_n, run, clear. Output `tick` when the count reaches DWELL-1.
- Top instantiates it and keeps the index register, FSM and output register.

Test Plan:
- Defaults, en=1, mode=0, sel=00,01,10,11 each 10ns -> y=0001,0010,0100,1000, each one cycle after sel; idx tracks sel.
- Direct with sel=10, then en=0 -> y=0000 next edge; idx holds 2; wrap stays 0.
- mode=1, en=1 from reset -> y=0001 for 4 cycles, then 0010, 0100, 1000 (4 cycles each), then 0001 with wrap=1 for that single cycle; repeats every 16 cycles.
- Scan at idx=2, dwell=1: drop en for 3 cycles -> y=0000. Raise en -> y=0100 for the remaining 2 cycles (resumes dwell 2, 3), then 1000. Separately, switch mode=0 with sel=01 mid-dwell -> y=0010 next edge.
- Assert rst_n=0 asynchronously mid-scan (idx=3) between clock edges -> y=0000, idx=0, wrap=0 immediately. After release with mode=1, scan restarts at 0001.
- SEL_W=3, DWELL=1, ACTIVE_LOW=1, scan -> y walks 11111110, 11111101, ..., 01111111; wrap pulses every 8 cycles. en=0 -> y=11111111.
